// File: rtl/uart_tx_core.sv
// UART 8N1/8N2 transmitter with valid/ready byte input, LSB-first serialisation.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module uart_tx_core #(
  parameter int unsigned CLK_DIV    = 5207,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic [6:0] level_o
);

  if (CLK_DIV < 1 || CLK_DIV > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_core: illegal parameter value");
  end

  localparam logic [15:0] DIV       = 16'(CLK_DIV);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [7:0]  sreg;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic        baud_end;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  assign baud_end = (baud_cnt == DIV);
  assign push     = valid_i && !full;
  // Pop happens when idle, or at the final stop-bit cycle so the next start bit follows with no gap.
  assign pop      = !empty && ((state == IDLE) ||
                    (state == STOP && baud_end && bit_cnt == LAST_STOP));
  assign ready_o  = !full;
  assign busy_o   = (state != IDLE) || (level_o != '0);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_o <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: level_o <= level_o;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       hold_vld;

  assign empty   = !hold_vld;
  assign full    = hold_vld;
  assign head    = hold;
  assign level_o = {6'b0, hold_vld};

  // push requires !full and pop requires !empty, so both never coincide here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (push) begin
      hold     <= data_i;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_o     <= 1'b1;
      sreg     <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            sreg     <= head;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_o     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx_o     <= sreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            sreg     <= {1'b0, sreg[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              tx_o    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_o    <= sreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (pop) begin
                sreg  <= head;
                tx_o  <= 1'b0;
                state <= START;
              end else begin
                tx_o  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: two instances at CLK_DIV=3, one with 1 and one with 2 stop bits.
module tb_uart_tx_core;

`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid1, valid2;
  logic       rdy1, tx1, busy1;
  logic       rdy2, tx2, busy2;
  logic [6:0] lvl1, lvl2;

  int         sel;
  logic       s_tx, s_rdy, s_busy;
  logic [6:0] s_lvl;

  int         n_cmp = 0;
  int         n_err = 0;

  logic [7:0] src[$];
  int         acc_k[$];
  logic [6:0] lvl_h[256];
  logic       rdy_h[256];
  logic       busy_h[256];
  logic       e0_tx, e0_busy;
  logic [6:0] e0_lvl;

  uart_tx_core #(.CLK_DIV(3), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid1),
    .ready_o(rdy1), .tx_o(tx1), .busy_o(busy1), .level_o(lvl1)
  );

  uart_tx_core #(.CLK_DIV(3), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid2),
    .ready_o(rdy2), .tx_o(tx2), .busy_o(busy2), .level_o(lvl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_tx   = (sel != 0) ? tx2   : tx1;
    s_rdy  = (sel != 0) ? rdy2  : rdy1;
    s_busy = (sel != 0) ? busy2 : busy1;
    s_lvl  = (sel != 0) ? lvl2  : lvl1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s != 0) valid2 = v;
    else        valid1 = v;
  endtask

  // Pushes every byte of src with handshake; edge E0 takes the first byte, then ncyc cycles
  // from the first pop are checked against the ideal back-to-back frame train.
  task automatic run(input int s, input int sb, input int ncyc);
    int         idx;
    int         frame_len;
    int         fr;
    int         b;
    logic       r;
    logic       exp_tx;
    logic [7:0] cur;
    sel       = s;
    idx       = 0;
    frame_len = (9 + sb) * 4;
    acc_k.delete();
    data = src[0];
    set_valid(s, 1'b1);
    r = s_rdy;
    tick();
    if (r) begin
      acc_k.push_back(-1);
      idx++;
    end
    if (idx < src.size()) data = src[idx];
    set_valid(s, idx < src.size());
    e0_tx   = s_tx;
    e0_lvl  = s_lvl;
    e0_busy = s_busy;
    for (int k = 0; k < ncyc; k++) begin
      r = s_rdy;
      tick();
      if (r && idx < src.size()) begin
        acc_k.push_back(k);
        idx++;
      end
      if (idx < src.size()) data = src[idx];
      set_valid(s, idx < src.size());
      fr = k / frame_len;
      b  = (k % frame_len) / 4;
      if (fr >= src.size()) exp_tx = 1'b1;
      else if (b == 0)      exp_tx = 1'b0;
      else if (b <= 8) begin
        cur    = src[fr];
        exp_tx = cur[b-1];
      end else              exp_tx = 1'b1;
      chk($sformatf("tx k=%0d", k), 32'(s_tx), 32'(exp_tx));
      if (k < 256) begin
        lvl_h[k]  = s_lvl;
        rdy_h[k]  = s_rdy;
        busy_h[k] = s_busy;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int early;
    sel    = 0;
    data   = '0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    rst_n  = 1'b0;

    // reset held for 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst tx c%0d", i),    32'(tx1),   32'd1);
      chk($sformatf("rst ready c%0d", i), 32'(rdy1),  32'd1);
      chk($sformatf("rst busy c%0d", i),  32'(busy1), 32'd0);
      chk($sformatf("rst level c%0d", i), 32'(lvl1),  32'd0);
    end
    chk("rst tx2", 32'(tx2), 32'd1);
    chk("rst busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    tick();

    // single byte 0x41
    src = '{8'h41};
    run(0, 1, 40);
    chk("single accept edge", 32'(acc_k[0]), 32'hFFFF_FFFF);
    chk("single e0 tx", 32'(e0_tx), 32'd1);
    chk("single e0 level", 32'(e0_lvl), 32'd1);
    chk("single e0 busy", 32'(e0_busy), 32'd1);
    chk("single busy last cycle", 32'(busy_h[39]), 32'd1);
    tick();
    chk("single busy after", 32'(busy1), 32'd0);
    chk("single tx after", 32'(tx1), 32'd1);

    // back-to-back 0x55, 0xA3
    src = '{8'h55, 8'hA3};
    run(0, 1, 80);
    chk("b2b accepted", 32'(acc_k.size()), 32'd2);
    chk("b2b level before pop2", 32'(lvl_h[39]), 32'd1);
    chk("b2b level after pop2", 32'(lvl_h[40]), 32'd0);
    tick();
    chk("b2b busy after", 32'(busy1), 32'd0);

    // overflow with valid held high
    src = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h96, 8'h5A};
    run(0, 1, 240);
    early = 0;
    foreach (acc_k[i]) if (acc_k[i] <= 3) early++;
    chk("ovf accepted early", 32'(early), 32'(CAP + 1));
    chk("ovf ready when full", 32'(rdy_h[3]), 32'd0);
    chk("ovf level when full", 32'(lvl_h[3]), 32'(CAP));
    chk("ovf all accepted", 32'(acc_k.size()), 32'd6);
    if (acc_k.size() > CAP + 1)
      chk("ovf next accept edge", 32'(acc_k[CAP+1]), 32'd41);
    else
      chk("ovf next accept present", 32'(acc_k.size()), 32'(CAP + 2));
    tick();
    chk("ovf busy after", 32'(busy1), 32'd0);

    // two stop bits, 0xFF
    src = '{8'hFF};
    run(1, 2, 44);
    chk("stop2 busy last cycle", 32'(busy_h[43]), 32'd1);
    tick();
    chk("stop2 busy after", 32'(busy2), 32'd0);
    chk("stop2 tx after", 32'(tx2), 32'd1);

    // reset during bit 3 of 0x00 with a second byte buffered
    src = '{8'h00, 8'h77};
    run(0, 1, 18);
    chk("mid tx low pre-reset", 32'(tx1), 32'd0);
    chk("mid level pre-reset", 32'(lvl1), 32'd1);
    #2 rst_n = 1'b0;
    valid1 = 1'b0;
    #1;
    chk("mid tx async", 32'(tx1), 32'd1);
    chk("mid level async", 32'(lvl1), 32'd0);
    chk("mid busy async", 32'(busy1), 32'd0);
    chk("mid ready async", 32'(rdy1), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("post-reset tx idle", 32'(tx1), 32'd1);

    src = '{8'h12};
    run(0, 1, 40);
    tick();
    chk("post-reset busy after", 32'(busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
